// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch front end for the 16-bit pipelined processor. Owns the
// fetch PC, issues reads to a fixed 1-cycle-latency instruction memory,
// buffers returned words in a small FIFO and presents one instruction per
// cycle (with its PC) to decode over a valid/ready handshake. A redirect from
// decode flushes the FIFO, reloads the fetch PC and discards any stale read.
//
// Optional build macro:
//   IFQ_BYPASS_EN - when the FIFO is empty, a fresh memory response is driven
//                   straight to ir/ir_pc in the cycle it arrives (1-cycle
//                   request-to-valid latency). Undefined: every response goes
//                   through the FIFO (2-cycle latency, outputs depend only on
//                   registered state).
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset
//   NOP_WORD  value driven on ir while ir_valid=0
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   imem_req     read request to instruction memory this cycle
//   imem_addr    read address (the fetch PC)
//   imem_data    read data, valid with imem_valid
//   imem_valid   read data strobe, exactly 1 cycle after imem_req
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address
//   halt         stop issuing new requests
//   ir_ready     decode accepts ir this cycle
//   ir_valid     ir/ir_pc hold a valid instruction
//   ir           instruction word at the FIFO head
//   ir_pc        address of ir
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        fpc_q, fpc_d;
  logic [15:0]        tag_q, tag_d;          // address of the read in flight
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;        // discard the next response
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [15:0]        mem_word_q [DEPTH];
  logic [15:0]        mem_pc_q   [DEPTH];

  logic               fifo_empty;
  logic               resp_ok;
  logic               bypass;
  logic               bypass_take;
  logic               push;
  logic               pop;
  logic               credit_ok;
  logic               issue;
  logic [CNT_W:0]     occupancy;

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fifo_empty = (count_q == '0);

    // A response counts only if it belongs to the current fetch stream: not
    // flagged stale, not killed by a redirect this cycle, not during reset.
    resp_ok = reset && imem_valid && !drop_q && !redirect;

`ifdef IFQ_BYPASS_EN
    bypass      = fifo_empty && resp_ok;
    bypass_take = bypass && ir_ready;
`else
    bypass      = 1'b0;
    bypass_take = 1'b0;
`endif

    push = resp_ok && !bypass_take;
    pop  = !fifo_empty && ir_ready && !redirect;

    // Credit includes the in-flight read so its response always has a slot.
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    credit_ok = (occupancy < DEPTH_C);
    issue     = reset && (state_q == ST_FETCH) && !redirect && credit_ok;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      ST_FETCH: if (halt)              state_d = ST_STALL;
      ST_STALL: if (redirect && !halt) state_d = ST_FETCH;
      default:                         state_d = ST_FETCH;
    endcase

    if (issue) begin
      fpc_d      = fpc_q + 16'd1;  // wraps FFFF -> 0000
      tag_d      = fpc_q;
      inflight_d = 1'b1;
    end else if (imem_valid) begin
      inflight_d = 1'b0;
    end

    if (imem_valid && drop_q) begin
      drop_d = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Redirect overrides everything above. A response arriving this cycle is
    // already discarded via resp_ok; only a read still outstanding after this
    // cycle needs the drop flag.
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fpc_d      = redirect_pc;
      drop_d     = inflight_q && !imem_valid;
      inflight_d = inflight_q && !imem_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      fpc_q      <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read,
  // so stale contents are never visible and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= imem_data;
      mem_pc_q[wr_ptr_q]   <= tag_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = issue;
    imem_addr = fpc_q;
    ir_valid  = 1'b0;
    ir        = NOP_WORD;
    ir_pc     = 16'h0000;
    if (bypass) begin
      ir_valid = 1'b1;
      ir       = imem_data;
      ir_pc    = tag_q;
    end else if (!fifo_empty) begin
      ir_valid = 1'b1;
      ir       = mem_word_q[rd_ptr_q];
      ir_pc    = mem_pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Self-checking bench for instr_fetch_queue. A 1-cycle memory model returns
// addr ^ 16'hA5A5. Every observed request is checked against a model fetch PC
// and its expected {word, pc} is pushed to a scoreboard; every accepted
// instruction pops and compares. Redirects clear the scoreboard and reload the
// model PC.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam logic [15:0] NOP = 16'hFFFF;
  localparam logic [15:0] KEY = 16'hA5A5;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        ir_ready;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_pc;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (16'h0000),
    .NOP_WORD (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ir_ready    (ir_ready),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  sb_entry_t   sb[$];
  logic [15:0] popped_pc[$];
  logic [15:0] popped_ir[$];
  logic [15:0] exp_fpc;
  logic        pend_valid;
  logic [15:0] pend_addr;
  logic        obs_req;
  logic [15:0] obs_addr;
  logic        obs_valid;
  logic [15:0] obs_ir;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at a negedge; holds reset low for two edges, checks the reset
  // outputs and returns at a negedge with reset released.
  task automatic do_reset();
    reset      = 1'b0;
    redirect   = 1'b0;
    redirect_pc = 16'h0000;
    halt       = 1'b0;
    ir_ready   = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    pend_valid = 1'b0;
    pend_addr  = 16'h0000;
    sb.delete();
    exp_fpc = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req",  imem_req,  0);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_ir_valid",  ir_valid,  0);
    check("rst_ir",        ir,        NOP);
    check("rst_ir_pc",     ir_pc,     16'h0000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock cycle. Entered at a negedge: drive inputs plus the memory
  // response owed from last cycle, sample outputs, update the scoreboard,
  // then advance to the next negedge.
  task automatic tick(input logic rd, input logic [15:0] rpc, input logic hlt, input logic rdy);
    sb_entry_t e;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hlt;
    ir_ready    = rdy;
    imem_valid  = pend_valid;
    imem_data   = pend_addr ^ KEY;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = ir_valid;
    obs_ir    = ir;
    if (!ir_valid) check("ir_nop_when_invalid", ir, NOP);
    if (rd) begin
      check("req_on_redirect", imem_req, 0);
      sb.delete();
      exp_fpc = rpc;
    end else begin
      if (ir_valid && rdy) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ir_word", ir,    e.word);
          check("ir_pc",   ir_pc, e.pc);
        end
        popped_pc.push_back(ir_pc);
        popped_ir.push_back(ir);
      end
      if (imem_req) begin
        check("imem_addr", imem_addr, exp_fpc);
        e.word = exp_fpc ^ KEY;
        e.pc   = exp_fpc;
        sb.push_back(e);
        exp_fpc = exp_fpc + 16'd1;
      end
    end
    pend_valid = imem_req;
    pend_addr  = imem_addr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_req;
    int first_val;
    int cnt;
    logic found;

    reset = 1'b0;
    @(negedge clk);

    // ---- streaming from reset, latency and throughput ----
    do_reset();
    popped_pc.delete(); popped_ir.delete();
    first_req = -1; first_val = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      if (obs_req && first_req < 0) first_req = i;
      if (obs_valid && first_val < 0) first_val = i;
      if (obs_valid && first_val >= 0 && i > first_val) cnt++;
    end
    check("first_req_cycle", first_req, 0);
    check("req_to_valid_latency", first_val - first_req, LAT);
    check("steady_throughput", cnt, 11 - first_val);
    check("stream_pops", popped_pc.size() >= 1, 1);
    if (popped_pc.size() >= 1) begin
      check("first_ir",    popped_ir[0], 16'hA5A5);
      check("first_ir_pc", popped_pc[0], 16'h0000);
    end

    // ---- fill with ir_ready low, then drain and refill ----
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      if (obs_req) cnt++;
    end
    check("full_req_count", cnt, 4);
    check("full_no_req", obs_req, 0);
    check("full_valid", obs_valid, 1);
    popped_pc.delete(); popped_ir.delete();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      if (obs_valid) cnt++;
    end
    check("refill_no_gap", cnt, 10);
    check("drain_pops", popped_pc.size(), 10);
    if (popped_pc.size() >= 4)
      for (int i = 0; i < 4; i++) check("drain_order", popped_pc[i], i);

    // ---- redirect on the cycle after the request to 5 ----
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      if (obs_req && obs_addr == 16'h0005) found = 1'b1;
    end
    check("saw_req_5", found, 1);
    tick(1'b1, 16'h0040, 1'b0, 1'b1);
    popped_pc.delete(); popped_ir.delete();
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("redir_req", obs_req, 1);
    check("redir_addr", obs_addr, 16'h0040);
    for (int i = 0; i < 6 && popped_pc.size() == 0; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("redir_popped", popped_pc.size() != 0, 1);
    if (popped_pc.size() != 0) check("redir_first_pc", popped_pc[0], 16'h0040);

    // ---- redirect together with a pop while the FIFO holds 3 ----
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b0, 1'b0);
    tick(1'b1, 16'h0080, 1'b0, 1'b1);
    check("flush_pre_valid", obs_valid, 1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("flush_valid_after", obs_valid, 0);
    check("flush_ir_after", obs_ir, NOP);
    popped_pc.delete(); popped_ir.delete();
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("flush_popped", popped_pc.size() != 0, 1);
    if (popped_pc.size() != 0) check("flush_first_pc", popped_pc[0], 16'h0080);

    // ---- PC wrap ----
    tick(1'b1, 16'hFFFE, 1'b0, 1'b1);
    popped_pc.delete(); popped_ir.delete();
    for (int i = 0; i < 8; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("wrap_pops", popped_pc.size() >= 4, 1);
    if (popped_pc.size() >= 4) begin
      check("wrap_pc0", popped_pc[0], 16'hFFFE);
      check("wrap_pc1", popped_pc[1], 16'hFFFF);
      check("wrap_pc2", popped_pc[2], 16'h0000);
      check("wrap_pc3", popped_pc[3], 16'h0001);
    end

    // ---- halt, drain, stall behaviour ----
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0, 1'b1, 1'b1);
      if (obs_req) cnt++;
    end
    check("halt_no_req", cnt, 0);
    check("halt_drained", obs_valid, 0);
    check("halt_drained_ir", obs_ir, NOP);
    check("halt_sb_empty", sb.size(), 0);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      if (obs_req) cnt++;
    end
    check("stall_holds", cnt, 0);
    tick(1'b1, 16'h0100, 1'b1, 1'b1);
    tick(1'b0, 16'h0, 1'b1, 1'b1);
    check("stall_redirect_halted", obs_req, 0);
    tick(1'b1, 16'h0200, 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("resume_req", obs_req, 1);
    check("resume_addr", obs_addr, 16'h0200);
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);

    // ---- asynchronous reset mid-fetch ----
    #3;
    check("pre_async_valid", ir_valid, 1);
    reset = 1'b0;
    #1;
    check("async_imem_req",  imem_req,  0);
    check("async_imem_addr", imem_addr, 16'h0000);
    check("async_ir_valid",  ir_valid,  0);
    check("async_ir",        ir,        NOP);
    check("async_ir_pc",     ir_pc,     16'h0000);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);
    check("post_reset_pops", popped_pc.size() != 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Instruction fetch front end that sits directly upstream of the decode/stage-0 logic of the 16-bit pipelined processor. Owns the fetch PC and issues reads to instruction memory (fixed 1-cycle latency). Buffers returned words in a small FIFO and presents one instruction per cycle, with its PC, to decode over a valid/ready handshake. Decode sends redirects for jump/jumpf/call/ret; on a redirect the block flushes the FIFO and drops any stale in-flight read.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
RESET_PC, 16'h0000, fetch PC loaded on reset
NOP_WORD, 16'hFFFF, value driven on ir when ir_valid=0

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  16  read address; valid when imem_req=1
imem_data  input  16  read data; valid when imem_valid=1
imem_valid  input  1  asserted exactly 1 cycle after each imem_req
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  16  new fetch address
halt  input  1  stop issuing new requests (trap retired)
ir_ready  input  1  decode accepts ir this cycle
ir_valid  output  1  ir/ir_pc hold a valid instruction
ir  output  16  instruction word at FIFO head
ir_pc  output  16  address of ir

Behaviour:
- Reset (reset=0, async): fpc=RESET_PC, count=0, inflight=0, drop=0, rd/wr pointers=0, state=FETCH. Outputs: imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=NOP_WORD, ir_pc=0. Reset mid-operation discards all FIFO contents and in-flight reads, with no exceptions.
- State machine:
  - FETCH -> STALL when halt=1.
  - STALL -> FETCH only on redirect=1 with halt=0.
  - Reset returns to FETCH.
- Issue rule (FETCH only): imem_req=1 iff count+inflight < DEPTH and redirect=0. imem_addr=fpc. On issue: fpc<=fpc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000), and the issued address is tagged into a 1-deep in-flight register.
- inflight: set on issue, cleared when imem_valid returns. It can never exceed 1 because latency is fixed at 1.
- Response: when imem_valid=1 and drop=0, write {imem_data, tagged pc} at wr pointer and increment count. When drop=1, discard the response and clear drop.
- Output: ir_valid = (count != 0). ir/ir_pc come from the head entry. Pop when ir_valid && ir_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count=DEPTH): no request issued. The credit rule guarantees a response is never lost.
- Empty: ir_valid=0, ir=NOP_WORD, pop ignored.
- Redirect (highest priority):
  - Same cycle: count<=0, pointers<=0, fpc<=redirect_pc, imem_req forced 0, any pop in that cycle ignored.
  - Drop flag: drop<=1 if a request is in flight; a response arriving the same cycle as the redirect is discarded.
  - Next cycle: first request is to redirect_pc.
- Redirect while STALL with halt=1: flush and load fpc, but remain in STALL.
- Latency without bypass: request in cycle N, data in N+1, ir_valid in N+2. Steady-state throughput is 1 instruction/cycle when DEPTH>=2 and ir_ready=1.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when count=0, imem_valid=1 and drop=0, the response is driven straight to ir/ir_pc with ir_valid=1 in the same cycle. If ir_ready=1 it is consumed without being written; otherwise it is written to the FIFO as normal. Request-to-ir_valid latency becomes 1 cycle.
- Not defined: all responses pass through the FIFO, giving 2-cycle latency. Outputs are purely registered-state driven.

Test Plan:
- Reset release with ir_ready=1 and imem returning word=addr^16'hA5A5: requests to 0,1,2,... on consecutive cycles; ir_valid first asserts 2 cycles after first imem_req; ir=16'hA5A5, ir_pc=0, then 1 instruction/cycle.
- ir_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, count=4, imem_req=0. Raise ir_ready: ir_pc 0,1,2,3 in order, refill resumes without gap or duplicate.
- Redirect to 16'h0040 on the cycle after a request to 5: response for 5 dropped; next imem_addr=16'h0040; first ir_pc after redirect is 16'h0040.
- Redirect and pop in the same cycle with count=3: FIFO empties, no pop side effects, ir_valid=0 next cycle.
- redirect_pc=16'hFFFE, ir_ready=1: ir_pc sequence FFFE, FFFF, 0000, 0001.
- halt=1 mid-stream: no new imem_req; FIFO drains; ir_valid=0 once empty. Assert reset=0 asynchronously mid-fetch: all outputs return to reset values before the next clk edge.
